watch_dp: RTL and testbench
===========================

WATCH_DP -- requirements
Module: watch_dp

Interface
REQ-001 Parameter: CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter: TICK_HZ, default 100, centisecond tick rate in Hz; CLK_FREQ/TICK_HZ SHALL be an integer >= 2.
REQ-003 Port: clk  input  1  system clock; single clock domain, all state on posedge clk.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: i_run_sec  input  1  one-cycle adjust pulse from watch control unit, seconds field.
REQ-006 Port: i_run_min  input  1  one-cycle adjust pulse, minutes field.
REQ-007 Port: i_run_hour  input  1  one-cycle adjust pulse, hours field.
REQ-008 Port: o_msec  output  7  centiseconds, 0..99.
REQ-009 Port: o_sec  output  6  seconds, 0..59.
REQ-010 Port: o_min  output  6  minutes, 0..59.
REQ-011 Port: o_hour  output  5  hours; 0..23, or 1..12 with WATCH_12H_EN.
REQ-012 Port: o_pm  output  1  PM flag; constant 0 without WATCH_12H_EN.

Function
REQ-013 Tick divider counts 0..CLK_FREQ/TICK_HZ-1 and wraps; internal tick asserts one cycle when the count equals the maximum.
REQ-014 All outputs driven directly from registers; an input pulse or tick sampled at edge N is visible on outputs after edge N, with 1-cycle latency and no combinational input-to-output path.
REQ-015 On tick: msec +1; 99->0 carries into sec.
REQ-016 Sec carry: sec +1; 59->0 carries into min. Min carry: min +1; 59->0 carries into hour. Hour carry: hour +1; 23->0 wraps silently.
REQ-017 Carry ripple completes in the same cycle as the tick: at 23:59:59.99 one tick yields 00:00:00.00 in one edge.
REQ-018 i_run_sec: sec +1 modulo 60, no carry into min; msec and tick divider unaffected.
REQ-019 i_run_min: min +1 modulo 60, no carry into hour. i_run_hour: hour +1 modulo range, no further carry.
REQ-020 Multiple adjust pulses in one cycle each apply to their own field independently.
REQ-021 Adjust pulse and tick-carry into the same field in one cycle: field advances by exactly 1 (adjust wins); that tick-carry is dropped and does not propagate upward.
REQ-022 Tick-carry into a field not being adjusted behaves per REQ-015..017 even when another field is adjusted the same cycle.
REQ-023 Held (multi-cycle) adjust input advances the field once per cycle held; no edge detection in this block.

Reset
REQ-024 rst sampled high at a clock edge SHALL clear the tick divider, set o_msec=0, o_sec=0, o_min=0, o_pm=0 and o_hour=0 (24h) or 12 (12h), regardless of concurrent tick or adjust inputs.
REQ-025 Reset mid-count discards any partial divider count; first tick after reset release occurs CLK_FREQ/TICK_HZ cycles after the release edge.

Configuration
REQ-026 Macro WATCH_12H_EN defined: hour range 1..12; sequence 11->12 toggles o_pm, 12->1 leaves o_pm unchanged; both tick-carry and i_run_hour obey this; reset = 12, AM.
REQ-027 WATCH_12H_EN undefined: hour range 0..23 per REQ-016; o_pm tied to 0; no 12h logic synthesized.

Verification (CLK_FREQ=1000, TICK_HZ=100, divider 10)
REQ-028 rst high 3 cycles, release -> outputs 00:00:00.00; first msec=1 exactly 10 cycles after release.
REQ-029 Preload 23:59:59.99 via adjusts plus ticks, apply one tick -> 00:00:00.00 on the next edge.
REQ-030 sec=59, one-cycle i_run_sec -> sec=0, min unchanged, msec and divider undisturbed.
REQ-031 msec=99, sec=59, i_run_sec coincident with tick -> msec=0, sec=0, min unchanged (carry dropped).
REQ-032 i_run_sec+i_run_min+i_run_hour same cycle from 00:00:00 -> 01:01:01 after one edge; rst asserted on a tick cycle -> all fields 0.
REQ-033 WATCH_12H_EN: from 11 AM one i_run_hour -> 12 PM; again -> 1 PM; after 11 further pulses -> 12 AM.

Source files
------------

// File: rtl/watch_dp.sv
// watch_dp -- time-of-day datapath for a digital watch.
//
// A tick divider generates one centisecond tick every CLK_FREQ/TICK_HZ
// cycles. Each tick advances centiseconds, and overflow ripples through
// seconds, minutes and hours in the same edge. One-cycle adjust pulses from
// the watch control unit advance a single field without carrying upward.
//
// Optional feature macro: WATCH_12H_EN
//   undefined : hours 0..23, o_pm tied low
//   defined   : hours 1..12 with AM/PM flag, reset value 12 AM
//
// Ports
//   clk        system clock, all state on posedge
//   rst        synchronous active-high reset
//   i_run_sec  adjust pulse, seconds field
//   i_run_min  adjust pulse, minutes field
//   i_run_hour adjust pulse, hours field
//   o_msec     centiseconds 0..99
//   o_sec      seconds 0..59
//   o_min      minutes 0..59
//   o_hour     hours (0..23 or 1..12)
//   o_pm       PM flag

module watch_dp #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int TICK_HZ  = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_run_sec,
   input  logic       i_run_min,
   input  logic       i_run_hour,
   output logic [6:0] o_msec,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic [4:0] o_hour,
   output logic       o_pm
);

   localparam int DIV = CLK_FREQ / TICK_HZ;
   localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

`ifdef WATCH_12H_EN
   localparam logic [4:0] HOUR_RST = 5'd12;
`else
   localparam logic [4:0] HOUR_RST = 5'd0;
`endif

   logic [CW-1:0] div_cnt;
   logic          tick;
   logic          ms_wrap;
   logic          sec_carry;
   logic          min_carry;
   logic          sec_adv;
   logic          min_adv;
   logic          hour_adv;
   logic [4:0]    hour_next;

   assign tick = (div_cnt == CW'(DIV - 1));

   // A field being adjusted in the same cycle swallows the incoming carry,
   // so the carry out of that field is suppressed as well.
   assign ms_wrap   = tick && (o_msec == 7'd99);
   assign sec_carry = ms_wrap && !i_run_sec && (o_sec == 6'd59);
   assign min_carry = sec_carry && !i_run_min && (o_min == 6'd59);

   assign sec_adv  = i_run_sec  | ms_wrap;
   assign min_adv  = i_run_min  | sec_carry;
   assign hour_adv = i_run_hour | min_carry;

`ifdef WATCH_12H_EN
   assign hour_next = (o_hour == 5'd12) ? 5'd1 : o_hour + 5'd1;
`else
   assign hour_next = (o_hour == 5'd23) ? 5'd0 : o_hour + 5'd1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         o_msec  <= 7'd0;
         o_sec   <= 6'd0;
         o_min   <= 6'd0;
         o_hour  <= HOUR_RST;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick)
            o_msec <= (o_msec == 7'd99) ? 7'd0 : o_msec + 7'd1;
         if (sec_adv)
            o_sec <= (o_sec == 6'd59) ? 6'd0 : o_sec + 6'd1;
         if (min_adv)
            o_min <= (o_min == 6'd59) ? 6'd0 : o_min + 6'd1;
         if (hour_adv)
            o_hour <= hour_next;
      end
   end

`ifdef WATCH_12H_EN
   // PM flips on 11->12 only; 12->1 keeps the current half of the day.
   always_ff @(posedge clk) begin
      if (rst)
         o_pm <= 1'b0;
      else if (hour_adv && (o_hour == 5'd11))
         o_pm <= ~o_pm;
   end
`else
   assign o_pm = 1'b0;
`endif

endmodule

// File: tb/tb_watch_dp.sv
module tb_watch_dp;

   localparam int CLK_FREQ = 1000;
   localparam int TICK_HZ  = 100;
   localparam int DIV      = CLK_FREQ / TICK_HZ;

`ifdef WATCH_12H_EN
   localparam logic [4:0] H_RST = 5'd12;
`else
   localparam logic [4:0] H_RST = 5'd0;
`endif

   typedef struct packed {
      logic [6:0] ms;
      logic [5:0] s;
      logic [5:0] mn;
      logic [4:0] h;
      logic       pm;
   } tod_t;

   typedef struct {
      logic rst;
      logic rs;
      logic rm;
      logic rh;
      int   n;
      tod_t exp;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       i_run_sec;
   logic       i_run_min;
   logic       i_run_hour;
   logic [6:0] o_msec;
   logic [5:0] o_sec;
   logic [5:0] o_min;
   logic [4:0] o_hour;
   logic       o_pm;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_cnt    = 0;
   tod_t m;
   tod_t sb_q[$];
   vec_t vecs[7];

   watch_dp #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_run_sec  (i_run_sec),
      .i_run_min  (i_run_min),
      .i_run_hour (i_run_hour),
      .o_msec     (o_msec),
      .o_sec      (o_sec),
      .o_min      (o_min),
      .o_hour     (o_hour),
      .o_pm       (o_pm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic tod_t tod(input int ms, input int s, input int mn,
                                input logic [4:0] h, input logic pm);
      tod_t t;
      t.ms = 7'(ms);
      t.s  = 6'(s);
      t.mn = 6'(mn);
      t.h  = h;
      t.pm = pm;
      return t;
   endfunction

   function automatic tod_t dut_tod();
      return {o_msec, o_sec, o_min, o_hour, o_pm};
   endfunction

   // Reference model: one clock edge of the watch.
   task automatic model_step(input logic r, input logic a, input logic b, input logic c);
      logic tk, c_sec, c_min, c_hour;
      if (r) begin
         m_cnt = 0;
         m     = tod(0, 0, 0, H_RST, 1'b0);
      end else begin
         tk     = (m_cnt == DIV - 1);
         m_cnt  = tk ? 0 : m_cnt + 1;
         c_sec  = tk && (m.ms == 7'd99);
         if (tk) m.ms = (m.ms == 7'd99) ? 7'd0 : m.ms + 7'd1;
         c_min  = c_sec && !a && (m.s == 6'd59);
         if (a || c_sec) m.s = (m.s == 6'd59) ? 6'd0 : m.s + 6'd1;
         c_hour = c_min && !b && (m.mn == 6'd59);
         if (b || c_min) m.mn = (m.mn == 6'd59) ? 6'd0 : m.mn + 6'd1;
         if (c || c_hour) begin
`ifdef WATCH_12H_EN
            if (m.h == 5'd11) m.pm = ~m.pm;
            m.h = (m.h == 5'd12) ? 5'd1 : m.h + 5'd1;
`else
            m.h = (m.h == 5'd23) ? 5'd0 : m.h + 5'd1;
`endif
         end
      end
   endtask

   task automatic show_fail(input string name, input tod_t got, input tod_t exp);
      $display("FAIL %s: got %0d:%0d:%0d.%0d pm=%0d, expected %0d:%0d:%0d.%0d pm=%0d",
               name, got.h, got.mn, got.s, got.ms, got.pm,
               exp.h, exp.mn, exp.s, exp.ms, exp.pm);
   endtask

   // Drive one cycle of inputs, queue the model's prediction, then compare
   // after the edge.
   task automatic cyc(input logic r, input logic a, input logic b, input logic c);
      tod_t exp, got;
      rst        = r;
      i_run_sec  = a;
      i_run_min  = b;
      i_run_hour = c;
      model_step(r, a, b, c);
      sb_q.push_back(m);
      @(posedge clk);
      #1;
      n_checks++;
      got = dut_tod();
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard: queue empty at time %0t", $time);
      end else begin
         exp = sb_q.pop_front();
         if (got !== exp) begin
            n_fail++;
            show_fail($sformatf("cycle@%0t", $time), got, exp);
         end
      end
   endtask

   task automatic expect_tod(input string name, input tod_t exp);
      tod_t got;
      got = dut_tod();
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         show_fail(name, got, exp);
      end
   endtask

   task automatic idle_until_rollover(input string name);
      int guard;
      guard = 0;
      while (!(m.ms == 7'd99 && m_cnt == DIV - 1) && guard < 3000) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
         guard++;
      end
      if (guard >= 3000) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: timeout waiting for msec=99 got %0d required 99", name, o_msec);
      end
   endtask

   initial begin
      rst        = 1'b1;
      i_run_sec  = 1'b0;
      i_run_min  = 1'b0;
      i_run_hour = 1'b0;

      // rst | sec | min | hour | cycles | expected after last cycle
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 3, tod(0, 0, 0, H_RST, 1'b0)};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, tod(0, 1, 1, 5'd1, 1'b0)};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, tod(0, 2, 1, 5'd1, 1'b0)};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 7, tod(0, 2, 1, 5'd1, 1'b0)};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, tod(1, 2, 1, 5'd1, 1'b0)};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 9, tod(1, 2, 1, 5'd1, 1'b0)};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, tod(0, 0, 0, H_RST, 1'b0)};

      for (int i = 0; i < 7; i++) begin
         for (int k = 0; k < vecs[i].n; k++)
            cyc(vecs[i].rst, vecs[i].rs, vecs[i].rm, vecs[i].rh);
         expect_tod($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Preload 23:59:59.99 (11:59:59.99 PM in 12h) and roll over in one tick.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 59; i++)
         cyc(1'b0, 1'b1, 1'b1, (i < 23) ? 1'b1 : 1'b0);
      idle_until_rollover("preload");
`ifdef WATCH_12H_EN
      expect_tod("preload_full", tod(99, 59, 59, 5'd11, 1'b1));
`else
      expect_tod("preload_full", tod(99, 59, 59, 5'd23, 1'b0));
`endif
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      expect_tod("midnight_rollover", tod(0, 0, 0, H_RST, 1'b0));

      // Seconds adjust wraps 59->0 without touching minutes or the divider.
      for (int i = 0; i < 59; i++)
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
      expect_tod("sec_hold59", tod(5, 59, 0, H_RST, 1'b0));
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      expect_tod("sec_adj_wrap", tod(6, 0, 0, H_RST, 1'b0));
      repeat (9) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      expect_tod("div_undisturbed_a", tod(6, 0, 0, H_RST, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      expect_tod("div_undisturbed_b", tod(7, 0, 0, H_RST, 1'b0));

      // Adjust coincident with the carry into seconds: carry is dropped.
      for (int i = 0; i < 59; i++)
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle_until_rollover("drop_carry");
      expect_tod("pre_drop_carry", tod(99, 59, 0, H_RST, 1'b0));
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      expect_tod("drop_carry", tod(0, 0, 0, H_RST, 1'b0));

      // Hour adjust runs the full range and returns without carry.
      repeat (24) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (o_hour !== H_RST || o_min !== 6'd0 || o_pm !== 1'b0) begin
         n_fail++;
         $display("FAIL hour_full_cycle: got h=%0d m=%0d pm=%0d expected h=%0d m=0 pm=0",
                  o_hour, o_min, o_pm, H_RST);
      end

`ifdef WATCH_12H_EN
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (11) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      expect_tod("h12_11am", tod(m.ms, 0, 0, 5'd11, 1'b0));
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      expect_tod("h12_12pm", tod(m.ms, 0, 0, 5'd12, 1'b1));
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      expect_tod("h12_1pm", tod(m.ms, 0, 0, 5'd1, 1'b1));
      repeat (11) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      expect_tod("h12_12am", tod(m.ms, 0, 0, 5'd12, 1'b0));
`endif

      // Random adjust traffic, including carries alongside unrelated adjusts.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 59; i++)
         cyc(1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 600; i++)
         cyc(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
